hyperbus_target: RTL and testbench



---
 rtl/hyperbus_target.sv | 262 ++++++++++++++++++++++++++
 tb/tb_hyperbus_target.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyperbus_target.sv
// HyperBus memory-side responder: decodes CA words, applies initial latency and
// turns bus data words into single-cycle backing-memory or register accesses.
module hyperbus_target #(
  parameter int          WIDTH          = 8,
  parameter int          TACC_COUNT     = 5,
  parameter int          MEM_ADDR_WIDTH = 16,
  parameter logic [15:0] ID0_VALUE      = 16'h0C81,
  parameter logic [15:0] ID1_VALUE      = 16'h0000,
  parameter logic [15:0] CR0_RESET      = 16'h8F17
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      csn,
  input  logic [2*WIDTH-1:0]        dq_i,
  input  logic [1:0]                rwds_i,
  output logic [2*WIDTH-1:0]        dq_o,
  output logic                      dq_oe,
  output logic [1:0]                rwds_o,
  output logic                      rwds_oe,
  output logic [MEM_ADDR_WIDTH-1:0] mem_adr,
  output logic                      mem_re,
  output logic                      mem_we,
  output logic [1:0]                mem_be,
  output logic [2*WIDTH-1:0]        mem_dat_o,
  input  logic [2*WIDTH-1:0]        mem_dat_i,
  output logic [15:0]               cr0_o
);

  localparam int BW = 2 * WIDTH;
  localparam int AW = MEM_ADDR_WIDTH;
  localparam logic [7:0] LAT_1X = 8'(TACC_COUNT - 1);
  localparam logic [7:0] LAT_2X = 8'(2 * TACC_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CA,
    S_LATENCY,
    S_READ,
    S_WRITE,
    S_REGWR,
    S_HOLD
  } state_t;

  state_t          state_q, state_d;
  logic            ca_step_q, ca_step_d;
  logic [15:0]     ca_hi_q, ca_hi_d;
  logic [15:0]     ca_mid_q, ca_mid_d;
  logic            is_read_q, is_read_d;
  logic            is_reg_q, is_reg_d;
  logic            linear_q, linear_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      lat_cnt_q, lat_cnt_d;
  logic [15:0]     cr0_q, cr0_d;
  logic [15:0]     cr1_q, cr1_d;

  logic            dq_oe_q, dq_oe_d;
  logic            rwds_oe_q, rwds_oe_d;
  logic [1:0]      rwds_o_q, rwds_o_d;
  logic [BW-1:0]   dq_q, dq_d;
  logic            sel_mem_q, sel_mem_d;
  logic [AW-1:0]   mem_adr_q, mem_adr_d;
  logic            mem_re_q, mem_re_d;
  logic            mem_we_q, mem_we_d;
  logic [1:0]      mem_be_q, mem_be_d;
  logic [BW-1:0]   mem_dat_q, mem_dat_d;

  logic [1:0]      lat_ind;
  logic [AW-1:0]   dec_addr;
  logic [AW-1:0]   next_addr;
  logic [15:0]     reg_rdata;

  assign lat_ind  = cr0_q[3] ? 2'b11 : 2'b00;
  assign dec_addr = AW'({ca_hi_q[12:0], ca_mid_q, dq_i[2:0]});

  // Wrapped bursts stay inside an aligned 16-word block.
  always_comb begin
    next_addr = addr_q + AW'(1);
    if (!linear_q) begin
      next_addr = {addr_q[AW-1:4], addr_q[3:0] + 4'd1};
    end
  end

  always_comb begin
    reg_rdata = 16'h0000;
    if (addr_q == AW'(12'h000)) begin
      reg_rdata = ID0_VALUE;
    end else if (addr_q == AW'(12'h001)) begin
      reg_rdata = ID1_VALUE;
    end else if (addr_q == AW'(12'h800)) begin
      reg_rdata = cr0_q;
    end else if (addr_q == AW'(12'h801)) begin
      reg_rdata = cr1_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    ca_step_d = ca_step_q;
    ca_hi_d   = ca_hi_q;
    ca_mid_d  = ca_mid_q;
    is_read_d = is_read_q;
    is_reg_d  = is_reg_q;
    linear_d  = linear_q;
    addr_d    = addr_q;
    lat_cnt_d = lat_cnt_q;
    cr0_d     = cr0_q;
    cr1_d     = cr1_q;
    dq_oe_d   = 1'b0;
    rwds_oe_d = 1'b0;
    rwds_o_d  = 2'b00;
    dq_d      = '0;
    sel_mem_d = 1'b0;
    mem_adr_d = '0;
    mem_re_d  = 1'b0;
    mem_we_d  = 1'b0;
    mem_be_d  = 2'b00;
    mem_dat_d = '0;

    // A deasserted chip select ends whatever phase is in progress.
    if (csn) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          ca_hi_d   = dq_i[15:0];
          ca_step_d = 1'b0;
          rwds_oe_d = 1'b1;
          rwds_o_d  = lat_ind;
          state_d   = S_CA;
        end
        S_CA: begin
          rwds_oe_d = 1'b1;
          rwds_o_d  = lat_ind;
          if (!ca_step_q) begin
            ca_mid_d  = dq_i[15:0];
            ca_step_d = 1'b1;
          end else begin
            is_read_d = ca_hi_q[15];
            is_reg_d  = ca_hi_q[14];
            linear_d  = ca_hi_q[13];
            addr_d    = dec_addr;
            if (!ca_hi_q[15] && ca_hi_q[14]) begin
              state_d = S_REGWR;
            end else begin
              lat_cnt_d = cr0_q[3] ? LAT_2X : LAT_1X;
              state_d   = S_LATENCY;
            end
          end
        end
        S_LATENCY: begin
          if (lat_cnt_q == 8'd0) begin
            state_d = is_read_q ? S_READ : S_WRITE;
            // Memory reads are requested one cycle ahead of the data word.
            if (is_read_q && !is_reg_q) begin
              mem_re_d  = 1'b1;
              mem_adr_d = addr_q;
            end
          end else begin
            lat_cnt_d = lat_cnt_q - 8'd1;
          end
        end
        S_READ: begin
          dq_oe_d   = 1'b1;
          rwds_oe_d = 1'b1;
          rwds_o_d  = 2'b10;
          addr_d    = next_addr;
          if (is_reg_q) begin
            dq_d = BW'(reg_rdata);
          end else begin
            sel_mem_d = 1'b1;
            mem_re_d  = 1'b1;
            mem_adr_d = next_addr;
          end
        end
        S_WRITE: begin
          addr_d = next_addr;
          if (!is_reg_q) begin
            mem_we_d  = 1'b1;
            mem_adr_d = addr_q;
            mem_dat_d = dq_i;
            mem_be_d  = ~rwds_i;
          end
        end
        S_REGWR: begin
          if (addr_q == AW'(12'h800)) begin
            cr0_d = dq_i[15:0];
          end else if (addr_q == AW'(12'h801)) begin
            cr1_d = dq_i[15:0];
          end
          state_d = S_HOLD;
        end
        S_HOLD: begin
          state_d = S_HOLD;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ca_step_q <= 1'b0;
      ca_hi_q   <= '0;
      ca_mid_q  <= '0;
      is_read_q <= 1'b0;
      is_reg_q  <= 1'b0;
      linear_q  <= 1'b0;
      addr_q    <= '0;
      lat_cnt_q <= '0;
      cr0_q     <= CR0_RESET;
      cr1_q     <= 16'h0000;
      dq_oe_q   <= 1'b0;
      rwds_oe_q <= 1'b0;
      rwds_o_q  <= 2'b00;
      dq_q      <= '0;
      sel_mem_q <= 1'b0;
      mem_adr_q <= '0;
      mem_re_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      mem_be_q  <= 2'b00;
      mem_dat_q <= '0;
    end else begin
      state_q   <= state_d;
      ca_step_q <= ca_step_d;
      ca_hi_q   <= ca_hi_d;
      ca_mid_q  <= ca_mid_d;
      is_read_q <= is_read_d;
      is_reg_q  <= is_reg_d;
      linear_q  <= linear_d;
      addr_q    <= addr_d;
      lat_cnt_q <= lat_cnt_d;
      cr0_q     <= cr0_d;
      cr1_q     <= cr1_d;
      dq_oe_q   <= dq_oe_d;
      rwds_oe_q <= rwds_oe_d;
      rwds_o_q  <= rwds_o_d;
      dq_q      <= dq_d;
      sel_mem_q <= sel_mem_d;
      mem_adr_q <= mem_adr_d;
      mem_re_q  <= mem_re_d;
      mem_we_q  <= mem_we_d;
      mem_be_q  <= mem_be_d;
      mem_dat_q <= mem_dat_d;
    end
  end

  // Memory read data is already registered, so it is muxed straight onto DQ.
  assign dq_o      = sel_mem_q ? mem_dat_i : dq_q;
  assign dq_oe     = dq_oe_q;
  assign rwds_o    = rwds_o_q;
  assign rwds_oe   = rwds_oe_q;
  assign mem_adr   = mem_adr_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_dat_o = mem_dat_q;
  assign cr0_o     = cr0_q;

endmodule

// File: tb/tb_hyperbus_target.sv
// Directed bench for hyperbus_target: register reads, CR0 write, linear and
// wrapped memory bursts, aborts and mid-transaction reset.
module tb_hyperbus_target;

  logic        clk;
  logic        rst;
  logic        csn;
  logic [15:0] dq_i;
  logic [1:0]  rwds_i;
  logic [15:0] dq_o;
  logic        dq_oe;
  logic [1:0]  rwds_o;
  logic        rwds_oe;
  logic [15:0] mem_adr;
  logic        mem_re;
  logic        mem_we;
  logic [1:0]  mem_be;
  logic [15:0] mem_dat_o;
  logic [15:0] mem_dat_i;
  logic [15:0] cr0_o;

  int checks;
  int errors;

  logic [15:0] mem [0:65535];

  hyperbus_target #(
    .WIDTH(8), .TACC_COUNT(5), .MEM_ADDR_WIDTH(16),
    .ID0_VALUE(16'h0C81), .ID1_VALUE(16'h0000), .CR0_RESET(16'h8F17)
  ) dut (
    .clk(clk), .rst(rst), .csn(csn), .dq_i(dq_i), .rwds_i(rwds_i),
    .dq_o(dq_o), .dq_oe(dq_oe), .rwds_o(rwds_o), .rwds_oe(rwds_oe),
    .mem_adr(mem_adr), .mem_re(mem_re), .mem_we(mem_we), .mem_be(mem_be),
    .mem_dat_o(mem_dat_o), .mem_dat_i(mem_dat_i), .cr0_o(cr0_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous backing memory with one cycle of read latency.
  always @(posedge clk) begin
    if (mem_re) mem_dat_i <= mem[mem_adr];
  end

  function automatic logic [47:0] mk_ca(input logic rw, input logic rs,
                                        input logic lin, input logic [31:0] wadr);
    mk_ca = {rw, rs, lin, wadr[31:3], 13'd0, wadr[2:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ca(input logic [47:0] ca);
    csn = 1'b0; dq_i = ca[47:32]; tick();
    dq_i = ca[31:16]; tick();
    dq_i = ca[15:0]; tick();
    dq_i = 16'h0000;
  endtask

  task automatic go_idle(input int n);
    csn = 1'b1; dq_i = 16'h0000; rwds_i = 2'b00;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; csn = 1'b1; dq_i = 16'h0000; rwds_i = 2'b00;
    repeat (3) tick();
    checks++;
    if (cr0_o !== 16'h8F17) begin
      errors++; $display("[TB] FAIL reset_cr0 got %h exp %h", cr0_o, 16'h8F17);
    end
    checks++;
    if ({dq_oe, rwds_oe, rwds_o, mem_re, mem_we, mem_be} !== 8'h00) begin
      errors++; $display("[TB] FAIL reset_enables got %b exp 00000000",
                         {dq_oe, rwds_oe, rwds_o, mem_re, mem_we, mem_be});
    end
    checks++;
    if ({dq_o, mem_adr, mem_dat_o} !== 48'h0) begin
      errors++; $display("[TB] FAIL reset_data got %h exp 0", {dq_o, mem_adr, mem_dat_o});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read_id();
    logic [47:0] ca;
    ca = mk_ca(1'b1, 1'b1, 1'b0, 32'h0);
    csn = 1'b0; dq_i = ca[47:32]; tick();
    checks++;
    if (rwds_oe !== 1'b1 || rwds_o !== 2'b00) begin
      errors++; $display("[TB] FAIL id_ca_rwds got oe=%b rwds=%b exp oe=1 rwds=00", rwds_oe, rwds_o);
    end
    dq_i = ca[31:16]; tick();
    dq_i = ca[15:0]; tick();
    dq_i = 16'h0000;
    for (int c = 3; c <= 7; c++) begin
      tick();
      checks++;
      if (dq_oe !== 1'b0 || mem_re !== 1'b0) begin
        errors++; $display("[TB] FAIL id_latency cycle %0d got dq_oe=%b mem_re=%b exp 0 0", c, dq_oe, mem_re);
      end
    end
    tick();
    checks++;
    if (dq_oe !== 1'b1 || rwds_o !== 2'b10 || dq_o !== 16'h0C81 || mem_re !== 1'b0) begin
      errors++; $display("[TB] FAIL id0_word got oe=%b rwds=%b dq=%h re=%b exp 1 10 0c81 0",
                         dq_oe, rwds_o, dq_o, mem_re);
    end
    tick();
    checks++;
    if (dq_o !== 16'h0000 || dq_oe !== 1'b1) begin
      errors++; $display("[TB] FAIL id1_word got dq=%h oe=%b exp 0000 1", dq_o, dq_oe);
    end
    go_idle(1);
    checks++;
    if (dq_oe !== 1'b0 || rwds_oe !== 1'b0) begin
      errors++; $display("[TB] FAIL id_end got dq_oe=%b rwds_oe=%b exp 0 0", dq_oe, rwds_oe);
    end
    go_idle(1);
  endtask

  task automatic test_linear_write();
    drive_ca(mk_ca(1'b0, 1'b0, 1'b1, 32'h10));
    for (int c = 3; c <= 7; c++) begin
      tick();
      checks++;
      if (mem_we !== 1'b0) begin
        errors++; $display("[TB] FAIL wr_latency cycle %0d got mem_we=%b exp 0", c, mem_we);
      end
    end
    dq_i = 16'hA5A5; rwds_i = 2'b00; tick();
    checks++;
    if ({mem_we, mem_adr, mem_be, mem_dat_o} !== {1'b1, 16'h0010, 2'b11, 16'hA5A5}) begin
      errors++; $display("[TB] FAIL wr_word0 got we=%b adr=%h be=%b dat=%h exp 1 0010 11 a5a5",
                         mem_we, mem_adr, mem_be, mem_dat_o);
    end
    dq_i = 16'h1234; rwds_i = 2'b01; tick();
    checks++;
    if ({mem_we, mem_adr, mem_be, mem_dat_o} !== {1'b1, 16'h0011, 2'b10, 16'h1234}) begin
      errors++; $display("[TB] FAIL wr_word1 got we=%b adr=%h be=%b dat=%h exp 1 0011 10 1234",
                         mem_we, mem_adr, mem_be, mem_dat_o);
    end
    dq_i = 16'hFFFF; rwds_i = 2'b11; tick();
    checks++;
    if ({mem_we, mem_adr, mem_be} !== {1'b1, 16'h0012, 2'b00}) begin
      errors++; $display("[TB] FAIL wr_masked got we=%b adr=%h be=%b exp 1 0012 00",
                         mem_we, mem_adr, mem_be);
    end
    go_idle(1);
    checks++;
    if (mem_we !== 1'b0) begin
      errors++; $display("[TB] FAIL wr_end got mem_we=%b exp 0", mem_we);
    end
    go_idle(1);
  endtask

  task automatic test_linear_read();
    drive_ca(mk_ca(1'b1, 1'b0, 1'b1, 32'h10));
    for (int c = 3; c <= 6; c++) begin
      tick();
      checks++;
      if (mem_re !== 1'b0) begin
        errors++; $display("[TB] FAIL rd_latency cycle %0d got mem_re=%b exp 0", c, mem_re);
      end
    end
    tick();
    checks++;
    if (mem_re !== 1'b1 || mem_adr !== 16'h0010 || dq_oe !== 1'b0) begin
      errors++; $display("[TB] FAIL rd_first_re got re=%b adr=%h oe=%b exp 1 0010 0", mem_re, mem_adr, dq_oe);
    end
    tick();
    checks++;
    if (dq_oe !== 1'b1 || rwds_o !== 2'b10 || dq_o !== 16'hBEEF || mem_adr !== 16'h0011) begin
      errors++; $display("[TB] FAIL rd_word0 got oe=%b rwds=%b dq=%h adr=%h exp 1 10 beef 0011",
                         dq_oe, rwds_o, dq_o, mem_adr);
    end
    tick();
    checks++;
    if (dq_o !== 16'hCAFE) begin
      errors++; $display("[TB] FAIL rd_word1 got %h exp cafe", dq_o);
    end
    go_idle(1);
    checks++;
    if (dq_oe !== 1'b0 || rwds_oe !== 1'b0 || mem_re !== 1'b0) begin
      errors++; $display("[TB] FAIL rd_end got oe=%b rwds_oe=%b re=%b exp 0 0 0", dq_oe, rwds_oe, mem_re);
    end
    go_idle(1);
  endtask

  task automatic test_wrapped_read();
    drive_ca(mk_ca(1'b1, 1'b0, 1'b0, 32'h1E));
    repeat (4) tick();
    tick();
    checks++;
    if (mem_re !== 1'b1 || mem_adr !== 16'h001E) begin
      errors++; $display("[TB] FAIL wrap_adr0 got re=%b adr=%h exp 1 001e", mem_re, mem_adr);
    end
    tick();
    checks++;
    if (dq_o !== 16'h1111 || mem_adr !== 16'h001F) begin
      errors++; $display("[TB] FAIL wrap_adr1 got dq=%h adr=%h exp 1111 001f", dq_o, mem_adr);
    end
    tick();
    checks++;
    if (dq_o !== 16'h2222 || mem_adr !== 16'h0010) begin
      errors++; $display("[TB] FAIL wrap_adr2 got dq=%h adr=%h exp 2222 0010", dq_o, mem_adr);
    end
    tick();
    checks++;
    if (dq_o !== 16'hBEEF) begin
      errors++; $display("[TB] FAIL wrap_word2 got %h exp beef", dq_o);
    end
    go_idle(2);
  endtask

  task automatic test_cr0_write();
    logic [47:0] ca;
    drive_ca(mk_ca(1'b0, 1'b1, 1'b0, 32'h800));
    dq_i = 16'h8F1F; rwds_i = 2'b11; tick();
    checks++;
    if (cr0_o !== 16'h8F1F || mem_we !== 1'b0) begin
      errors++; $display("[TB] FAIL cr0_write got cr0=%h we=%b exp 8f1f 0", cr0_o, mem_we);
    end
    go_idle(2);
    ca = mk_ca(1'b1, 1'b1, 1'b0, 32'h800);
    csn = 1'b0; dq_i = ca[47:32]; tick();
    checks++;
    if (rwds_oe !== 1'b1 || rwds_o !== 2'b11) begin
      errors++; $display("[TB] FAIL cr0_lat_ind got oe=%b rwds=%b exp 1 11", rwds_oe, rwds_o);
    end
    dq_i = ca[31:16]; tick();
    dq_i = ca[15:0]; tick();
    dq_i = 16'h0000;
    for (int c = 3; c <= 12; c++) begin
      tick();
      checks++;
      if (dq_oe !== 1'b0) begin
        errors++; $display("[TB] FAIL cr0_latency cycle %0d got dq_oe=%b exp 0", c, dq_oe);
      end
    end
    tick();
    checks++;
    if (dq_oe !== 1'b1 || rwds_o !== 2'b10 || dq_o !== 16'h8F1F) begin
      errors++; $display("[TB] FAIL cr0_readback got oe=%b rwds=%b dq=%h exp 1 10 8f1f", dq_oe, rwds_o, dq_o);
    end
    go_idle(2);
  endtask

  task automatic test_reset_midway();
    drive_ca(mk_ca(1'b1, 1'b0, 1'b1, 32'h10));
    repeat (2) tick();
    rst = 1'b1; csn = 1'b1; tick();
    checks++;
    if (cr0_o !== 16'h8F17 || dq_oe !== 1'b0 || rwds_oe !== 1'b0 || mem_re !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_reset got cr0=%h oe=%b rwds_oe=%b re=%b exp 8f17 0 0 0",
                         cr0_o, dq_oe, rwds_oe, mem_re);
    end
    rst = 1'b0;
    go_idle(2);
  endtask

  task automatic test_abort_write();
    drive_ca(mk_ca(1'b0, 1'b0, 1'b1, 32'h20));
    tick();
    csn = 1'b1; dq_i = 16'h5555; tick();
    checks++;
    if (dq_oe !== 1'b0 || rwds_oe !== 1'b0 || mem_we !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_enables got oe=%b rwds_oe=%b we=%b exp 0 0 0", dq_oe, rwds_oe, mem_we);
    end
    for (int c = 5; c <= 10; c++) begin
      tick();
      checks++;
      if (mem_we !== 1'b0) begin
        errors++; $display("[TB] FAIL abort_no_write cycle %0d got mem_we=%b exp 0", c, mem_we);
      end
    end
    drive_ca(mk_ca(1'b1, 1'b0, 1'b1, 32'h10));
    repeat (5) tick();
    tick();
    checks++;
    if (dq_oe !== 1'b1 || dq_o !== 16'hBEEF) begin
      errors++; $display("[TB] FAIL abort_next_read got oe=%b dq=%h exp 1 beef", dq_oe, dq_o);
    end
    go_idle(2);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; csn = 1'b1; dq_i = 16'h0000; rwds_i = 2'b00;
    mem_dat_i = 16'h0000;
    mem[16'h0010] = 16'hBEEF;
    mem[16'h0011] = 16'hCAFE;
    mem[16'h001E] = 16'h1111;
    mem[16'h001F] = 16'h2222;
    test_reset();
    test_read_id();
    test_linear_write();
    test_linear_read();
    test_wrapped_read();
    test_cr0_write();
    test_reset_midway();
    test_abort_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
